// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, stimulus FSM states and DDS tuning-word helper
package fir_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int PHASE_WIDTH = 24;
  localparam int FS_HZ = 1_000_000;
  localparam real TW_SCALE = (2.0 ** PHASE_WIDTH) / FS_HZ;
  typedef enum logic [1:0] {IDLE, LOOKUP, DRAIN, OUTPUT} state_e;
  function automatic logic [PHASE_WIDTH-1:0] tw_of(input real hz);
    return PHASE_WIDTH'($rtoi(hz * TW_SCALE + 0.5));
  endfunction
endpackage

// File: rtl/multitone_stim_gen_if.sv
// multitone_stim_gen_if: control, config and sample stream of the stimulus source
interface multitone_stim_gen_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int NUM_TONES = 6
);
  logic run;
  logic [NUM_TONES-1:0] tone_en;
  logic cfg_we;
  logic [2:0] cfg_addr;
  logic [PHASE_WIDTH-1:0] cfg_data;
  logic signed [DATA_WIDTH-1:0] x_out;
  logic x_valid;
  modport master (output run, tone_en, cfg_we, cfg_addr, cfg_data, input x_out, x_valid);
  modport slave (input run, tone_en, cfg_we, cfg_addr, cfg_data, output x_out, x_valid);
endinterface

// File: rtl/sine_lut_quarter.sv
// sine_lut_quarter: quarter-wave sine ROM with quadrant mirroring and registered signed output
module sine_lut_quarter #(
  parameter int LUT_ADDR = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [LUT_ADDR+1:0] phase_i,
  output logic signed [DATA_WIDTH-1:0] data_o
);
  localparam int DEPTH = 1 << LUT_ADDR;
  logic [14:0] rom [DEPTH];
  logic [LUT_ADDR-1:0] addr;
  logic signed [DATA_WIDTH-1:0] mag;
  // half-step offset keeps the table symmetric so mirroring needs no special end entries
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    assign rom[i] = 15'($rtoi(32767.0 * $sin(2.0 * 3.141592653589793 * (real'(i) + 0.5) / real'(4 * DEPTH)) + 0.5));
  end
  assign addr = phase_i[LUT_ADDR] ? ~phase_i[LUT_ADDR-1:0] : phase_i[LUT_ADDR-1:0];
  assign mag = $signed(DATA_WIDTH'(rom[addr]));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_o <= '0;
    else data_o <= phase_i[LUT_ADDR+1] ? -mag : mag;
  end
endmodule

// File: rtl/multitone_stim_gen.sv
// multitone_stim_gen: multi-tone DDS summing up to NUM_TONES sines into one sample per CLK_DIV clocks
module multitone_stim_gen import fir_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int LUT_ADDR = 8,
  parameter int NUM_TONES = 6,
  parameter int CLK_DIV = 100
) (
  input logic clk,
  input logic rst_n,
  multitone_stim_gen_if.slave bus
);
  localparam int SW = DATA_WIDTH + 3;
  localparam int KW = NUM_TONES > 1 ? $clog2(NUM_TONES) : 1;
  localparam int CW = $clog2(CLK_DIV);
  state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d, add_k_q;
  logic [CW-1:0] div_q;
  logic run_q, add_q, x_valid_q, tick;
  logic [NUM_TONES-1:0] en_q;
  logic signed [SW-1:0] sum_q;
  logic signed [DATA_WIDTH-1:0] x_out_q, lut_data;
  logic [PHASE_WIDTH-1:0] phase_q [NUM_TONES];
  logic [PHASE_WIDTH-1:0] tw_q [NUM_TONES];
  assign tick = div_q == CW'(CLK_DIV - 1);
  sine_lut_quarter #(.LUT_ADDR(LUT_ADDR), .DATA_WIDTH(DATA_WIDTH)) u_lut (
    .clk(clk), .rst_n(rst_n),
    .phase_i(phase_q[k_q][PHASE_WIDTH-1 -: LUT_ADDR+2]),
    .data_o(lut_data)
  );
  always_comb begin
    state_d = state_q;
    k_d = state_q == LOOKUP ? k_q + 1'b1 : '0;
    case (state_q)
      IDLE:    state_d = tick ? LOOKUP : IDLE;
      LOOKUP:  state_d = k_q == KW'(NUM_TONES - 1) ? DRAIN : LOOKUP;
      DRAIN:   state_d = OUTPUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
    end
  end
  // run is registered so the first tick lands exactly CLK_DIV cycles after it rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      div_q <= '0;
      add_q <= 1'b0;
      add_k_q <= '0;
      en_q <= '0;
      sum_q <= '0;
      x_out_q <= '0;
      x_valid_q <= 1'b0;
      for (int i = 0; i < NUM_TONES; i++) begin
        phase_q[i] <= '0;
        tw_q[i] <= '0;
      end
    end else begin
      run_q <= bus.run;
      div_q <= (!run_q || tick) ? '0 : div_q + 1'b1;
      add_q <= state_q == LOOKUP;
      add_k_q <= k_q;
      if (tick) en_q <= bus.tone_en;
      if (tick) sum_q <= '0;
      else if (add_q && en_q[add_k_q]) sum_q <= sum_q + SW'(lut_data);
      if (state_q == LOOKUP) phase_q[k_q] <= phase_q[k_q] + tw_q[k_q];
      if (bus.cfg_we && 32'(bus.cfg_addr) < NUM_TONES) tw_q[bus.cfg_addr] <= bus.cfg_data;
      x_valid_q <= state_q == OUTPUT;
      if (state_q == OUTPUT) x_out_q <= DATA_WIDTH'(sum_q >>> 3);
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(tick && state_q != IDLE)) else $error("tick outside IDLE");
  end
  assign bus.x_out = x_out_q;
  assign bus.x_valid = x_valid_q;
endmodule

// File: doc/multitone_stim_gen.md
# multitone_stim_gen

Multi-tone direct-digital-synthesis stimulus source for the FIR filter chain. It produces the signed sample stream that drives the filter `x_in` port. The stream is the sum of up to six programmable sine tones, for example 20/40 kHz stopband tones plus 50/60/80/100 kHz passband tones. Output is one sample per `CLK_DIV` clocks, with a one-cycle `x_valid` strobe.

## Interface
- `DATA_WIDTH`, 16: output sample width, signed.
- `PHASE_WIDTH`, 24: phase accumulator and tuning-word width.
- `LUT_ADDR`, 8: quarter-wave table address bits (256 entries).
- `NUM_TONES`, 6: number of tone channels. Range 1..8.
- `CLK_DIV`, 100: clocks per output sample. Must be at least `NUM_TONES`+4.
- `clk`  in  1: single clock, all logic on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `run`  in  1: sample-rate divider enable.
- `tone_en`  in  NUM_TONES: per-tone enable mask, sampled in the tick cycle.
- `cfg_we`  in  1: tuning-word write strobe.
- `cfg_addr`  in  3: tone index to write.
- `cfg_data`  in  PHASE_WIDTH: tuning word, unsigned.
- `x_out`  out  DATA_WIDTH: registered signed sample.
- `x_valid`  out  1: one-cycle strobe marking a new `x_out`.

## Operation
- Divider counts 0..`CLK_DIV`-1 while `run`=1. It holds at 0 while `run`=0.
- A tick is the cycle in which the divider equals `CLK_DIV`-1.
- FSM states are IDLE, LOOKUP, DRAIN and OUTPUT.
  - IDLE goes to LOOKUP on a tick. The tick also latches `tone_en`.
  - LOOKUP lasts `NUM_TONES` cycles, with tone index k = 0..N-1.
  - DRAIN lasts 1 cycle.
  - OUTPUT lasts 1 cycle, then the FSM returns to IDLE.
- In LOOKUP cycle k:
  - Present the table address from `phase[k]`.
  - Update `phase[k]` to `phase[k]` + `tw[k]`, wrapping modulo 2^`PHASE_WIDTH`.
  - Phases advance whether or not the tone is enabled.
- Table read has 1-cycle latency.
  - Sample data for tone k is added to the sum in the next cycle, but only if the latched enable bit k is 1.
  - The sum register is `DATA_WIDTH`+3 bits signed and is cleared on the tick.
- Sine mapping uses the top `LUT_ADDR`+2 phase bits.
  - The top 2 bits select the quadrant; the next `LUT_ADDR` bits form the address a.
  - Quadrants 1 and 3 use the mirrored address (~a).
  - Quadrants 2 and 3 negate the table value.
- Table entry i = round(32767·sin(2π(i+0.5)/2^(`LUT_ADDR`+2))). Entries are 15-bit unsigned, so negation never overflows.
- OUTPUT state:
  - `x_out` takes sum >>> 3 (arithmetic shift).
  - Worst case is 6·32767/8, so saturation is never needed.
  - `x_valid` is asserted.
- Config writes:
  - `cfg_we`=1 with `cfg_addr` < `NUM_TONES` writes `tw[cfg_addr]`. Other addresses are ignored.
  - A write in the same cycle as the phase update of that tone is allowed. The update uses the old word; the new word applies from the next sample.
- `run` falling mid-frame: the current frame completes and `x_valid` still fires.

## Timing
- Reset values:
  - `x_out`=0, `x_valid`=0.
  - All phases, tuning words, the sum and the divider are 0.
  - FSM is in IDLE and the latched enables are 0.
- Tick in cycle t:
  - LOOKUP runs over t+1..t+N.
  - DRAIN is t+N+1.
  - OUTPUT is t+N+2.
  - `x_out` and `x_valid` are visible in cycle t+N+3, with `x_valid` high for exactly that cycle.
- Sample period is exactly `CLK_DIV` cycles while `run`=1.
- The first tick comes `CLK_DIV` cycles after `run` rises.
- A tick outside IDLE is impossible given the `CLK_DIV` constraint. Assert this in simulation.
- Reset asserted mid-frame clears everything immediately, asynchronously. No `x_valid` follows.

## Structure
- Shared package `fir_pkg` holds:
  - `DATA_WIDTH` and `PHASE_WIDTH` constants.
  - The FSM state enum.
  - The tuning-word helper constant `TW_SCALE` = 2^`PHASE_WIDTH` / fs. With fs = 1 MHz (100 MHz clock, `CLK_DIV`=100), 50 kHz gives tw=838861.
- Sub-module `sine_lut_quarter`:
  - Synchronous ROM with a registered output.
  - Handles quadrant mirroring and negation.
  - Input is the top `LUT_ADDR`+2 phase bits; output is a `DATA_WIDTH` signed value.

## Test plan
- Reset, `run`=1, nothing written -> `x_valid` every 100 cycles, `x_out`=0, and the first strobe comes exactly `CLK_DIV`+`NUM_TONES`+3 cycles after `run` rises.
- Write `tw[0]`=2^22, `tone_en`=6'b000001 -> `x_out` repeats 12, 4095, -13, -4096.
- All `tw`=0, `tone_en`=6'h3F -> every sample is 6·101>>>3 = 75.
- Write to `cfg_addr`=7 -> no tuning-word change. Write `tw[2]` during its LOOKUP cycle -> that sample uses the old word and the next sample uses the new word.
- Toggle `tone_en` between ticks -> only the value present in the tick cycle affects the output.
- Assert `rst_n`=0 mid-LOOKUP -> outputs are 0 immediately, no strobe follows, and after release the timing matches the first scenario.
